bvurem_inv_search: RTL
======================

BVUREM_INV_SEARCH -- requirements
Module: bvurem_inv_search

Interface
REQ-001 SHALL have parameter W, default 4: operand and witness width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: a query is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a query.
REQ-006 SHALL have port mode, input, 2 bits: the predicate selector (see REQ-012).
REQ-007 SHALL have port s, input, W bits: the fixed operand.
REQ-008 SHALL have port t, input, W bits: the target value.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have ports x (output, W bits: witness) and found (output, 1 bit: the witness satisfies the predicate).

Function
REQ-012 SHALL select predicate P(c) by mode: 0: (c urem s) != t; 1: (c urem s) == t; 2: (s urem c) != t; 3: (s urem c) == t.
REQ-013 SHALL follow SMT-LIB urem semantics: a urem 0 = a; all arithmetic unsigned, W bits, no extension.
REQ-014 SHALL implement FSM states IDLE, SEARCH, DONE, encoded in 2 bits.
REQ-015 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-016 SHALL latch mode, s and t on acceptance, clear candidate counter cand (W bits) to 0, and enter SEARCH; input changes after acceptance SHALL have no effect.
REQ-017 SHALL evaluate P(cand) combinationally once per SEARCH cycle using latched operands.
REQ-018 On a SEARCH cycle with P(cand)=1, SHALL at the next edge load x=cand, found=1, and enter DONE.
REQ-019 On a SEARCH cycle with P(cand)=0 and cand=2^W-1, SHALL at the next edge load x=0, found=0, and enter DONE; cand SHALL never wrap.
REQ-020 On a SEARCH cycle with P(cand)=0 and cand<2^W-1, SHALL increment cand and stay in SEARCH.
REQ-021 SHALL give latency, in edges from acceptance to the first cycle with out_valid=1, of k+1 where k is the smallest satisfying candidate, or 2^W when none exists.
REQ-022 SHALL assert out_valid only in DONE; x and found SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid & out_ready at an edge, SHALL return to IDLE; a new query SHALL NOT be accepted in the same cycle.
REQ-024 SHALL return the least satisfying witness (ascending search order) whenever one exists.
REQ-025 SHALL drive x and found to 0 outside DONE.

Reset
REQ-026 SHALL, when rst_n=0 at an edge, set state=IDLE, cand=0, x=0, found=0, out_valid=0, in_ready=1 after that edge, including when reset arrives mid-SEARCH or in DONE.
REQ-027 SHALL discard any in-flight query on reset and never emit a result for it.

Verification
REQ-028 SHALL be verified with: W=4, mode=0, s=3, t=0 -> x=1, found=1, out_valid 2 edges after acceptance.
REQ-029 SHALL be verified with: W=4, mode=1, s=5, t=4 -> x=4, found=1, latency 5; and mode=1, s=3, t=3 -> x=0, found=0, latency 16.
REQ-030 SHALL be verified with: W=4, mode=0, s=0, t=0 -> x=1, found=1 (urem-by-zero path); and mode=2, s=0, t=0 -> found=0, x=0.
REQ-031 SHALL be verified with: W=4, mode=3, s=7, t=1 -> x=2, found=1, latency 3.
REQ-032 SHALL be verified with: out_ready held 0 for 10 cycles in DONE -> out_valid, x and found stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-033 SHALL be verified with: rst_n=0 for one edge during SEARCH at cand=5 -> IDLE and in_ready=1 after that edge, no out_valid; plus an exhaustive check of all s, t and mode at W=4 against a reference model.

Source files
------------

// File: rtl/bvurem_inv_search_if.sv
// Query/result handshake bundle for the bvurem inverse-witness search block.
// The master drives queries and consumes results; the slave is the search engine.
interface bvurem_inv_search_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         found;

    modport master (
        output in_valid, mode, s, t, out_ready,
        input  in_ready, out_valid, x, found
    );

    modport slave (
        input  in_valid, mode, s, t, out_ready,
        output in_ready, out_valid, x, found
    );
endinterface

// File: rtl/bvurem_inv_search.sv
// Sequential ascending search for the least W-bit c satisfying a urem predicate
// (c urem s or s urem c compared against t), one candidate per cycle.
module bvurem_inv_search #(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bvurem_inv_search_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cand_q, cand_d;
    logic [W-1:0] x_q, x_d;
    logic         found_q, found_d;
    logic [1:0]   mode_q, mode_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] t_q, t_d;

    logic [W-1:0] rem_cs;
    logic [W-1:0] rem_sc;
    logic         hit;
    logic         accept;

    // Division by zero returns the dividend unchanged.
    function automatic logic [W-1:0] urem(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) begin
            return a;
        end
        return a % b;
    endfunction

    always_comb begin
        rem_cs = urem(cand_q, s_q);
        rem_sc = urem(s_q, cand_q);
        case (mode_q)
            2'd0:    hit = (rem_cs != t_q);
            2'd1:    hit = (rem_cs == t_q);
            2'd2:    hit = (rem_sc != t_q);
            default: hit = (rem_sc == t_q);
        endcase
    end

    assign accept = bus.in_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        x_d     = x_q;
        found_d = found_q;
        mode_d  = mode_q;
        s_d     = s_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = bus.mode;
                    s_d     = bus.s;
                    t_d     = bus.t;
                    cand_d  = '0;
                    x_d     = '0;
                    found_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    x_d     = cand_q;
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (cand_q == '1) begin
                    // Last candidate exhausted: report no witness rather than wrapping.
                    x_d     = '0;
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    cand_d = cand_q + W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    x_d     = '0;
                    found_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            x_q     <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            x_q     <= x_d;
            found_q <= found_d;
        end
    end

    // Operand registers are only meaningful after an acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        s_q    <= s_d;
        t_q    <= t_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.x         = (state_q == DONE) ? x_q : '0;
    assign bus.found     = (state_q == DONE) ? found_q : 1'b0;

endmodule
